reg_scoreboard: RTL and testbench

Register-busy scoreboard for the ARM pipeline. Records destination writes as instructions issue from ID and clears them as instructions write back, so the in-flight destination state is kept locally rather than compared against EXE/MEM stage fields. Drives a registered-state stall to the ID stage, with a forwarding-aware mode that stalls only on pending loads.

---
 rtl/reg_scoreboard.sv | 104 ++++++++++
 tb/tb_reg_scoreboard.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register-busy scoreboard: per-register in-flight writer/load counters feeding
// the ID-stage stall, with a forwarding-aware mode that only stalls on loads.
module reg_scoreboard #(
  parameter int unsigned REG_COUNT = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned CNT_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic                 issue_wb_en,
  input  logic                 issue_is_load,
  input  logic [ADDR_W-1:0]    issue_dest,
  input  logic                 flush,
  input  logic                 wb_valid,
  input  logic [ADDR_W-1:0]    wb_dest,
  input  logic                 wb_was_load,
  input  logic [ADDR_W-1:0]    src1_address,
  input  logic [ADDR_W-1:0]    src2_address,
  input  logic                 have_two_src,
  input  logic                 ignore_hazard,
  input  logic                 forward_en,
  output logic                 stall,
  output logic [REG_COUNT-1:0] busy_vector,
  output logic                 err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] pend_q [REG_COUNT];
  logic [CNT_W-1:0] ldp_q  [REG_COUNT];
  logic [CNT_W-1:0] pend_d [REG_COUNT];
  logic [CNT_W-1:0] ldp_d  [REG_COUNT];
  logic [CNT_W:0]   pend_nx [REG_COUNT];
  logic [CNT_W:0]   ldp_nx  [REG_COUNT];
  logic [REG_COUNT-1:0] err_vec;
  logic                 err_q;
  logic                 acc_c;
  logic                 hit1_c;
  logic                 hit2_c;

  // Returns {overflow/underflow flag, next count}; simultaneous +1/-1 cancel.
  function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] cnt,
                                          input logic inc, input logic dec);
    logic [CNT_W:0] res;
    res = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == CNT_MAX) res[CNT_W] = 1'b1;
      else                res[CNT_W-1:0] = cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt == '0) res[CNT_W] = 1'b1;
      else           res[CNT_W-1:0] = cnt - CNT_W'(1);
    end
    return res;
  endfunction

  // Hazard query against registered counters only; no same-cycle bypass.
  always_comb begin
    hit1_c = forward_en ? (ldp_q[src1_address] != '0) : (pend_q[src1_address] != '0);
    hit2_c = forward_en ? (ldp_q[src2_address] != '0) : (pend_q[src2_address] != '0);
    stall  = ~ignore_hazard & (hit1_c | (have_two_src & hit2_c));
    acc_c  = issue_valid & issue_wb_en & ~flush & ~stall;
  end

  always_comb begin
    for (int r = 0; r < REG_COUNT; r++) begin
      busy_vector[r] = (pend_q[r] != '0);
    end
  end

  // Next-state counters; load count is kept no larger than the writer count.
  always_comb begin
    for (int r = 0; r < REG_COUNT; r++) begin
      pend_nx[r] = bump(pend_q[r],
                        acc_c && (issue_dest == ADDR_W'(r)),
                        wb_valid && (wb_dest == ADDR_W'(r)));
      ldp_nx[r]  = bump(ldp_q[r],
                        acc_c && issue_is_load && (issue_dest == ADDR_W'(r)),
                        wb_valid && wb_was_load && (wb_dest == ADDR_W'(r)));
      pend_d[r]  = pend_nx[r][CNT_W-1:0];
      ldp_d[r]   = (ldp_nx[r][CNT_W-1:0] > pend_d[r]) ? pend_d[r] : ldp_nx[r][CNT_W-1:0];
      err_vec[r] = pend_nx[r][CNT_W] | ldp_nx[r][CNT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        pend_q[r] <= '0;
        ldp_q[r]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < REG_COUNT; r++) begin
        pend_q[r] <= pend_d[r];
        ldp_q[r]  <= ldp_d[r];
      end
      err_q <= err_q | (|err_vec);
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus randomized
// traffic compared against an integer-count reference model.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_wb_en;
  logic        issue_is_load;
  logic [3:0]  issue_dest;
  logic        flush;
  logic        wb_valid;
  logic [3:0]  wb_dest;
  logic        wb_was_load;
  logic [3:0]  src1_address;
  logic [3:0]  src2_address;
  logic        have_two_src;
  logic        ignore_hazard;
  logic        forward_en;
  logic        stall;
  logic [15:0] busy_vector;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integer counts of in-flight writers and loads.
  int m_pend [16];
  int m_ldp  [16];
  bit m_err;

  reg_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
    .issue_is_load(issue_is_load), .issue_dest(issue_dest),
    .flush(flush), .wb_valid(wb_valid), .wb_dest(wb_dest),
    .wb_was_load(wb_was_load), .src1_address(src1_address),
    .src2_address(src2_address), .have_two_src(have_two_src),
    .ignore_hazard(ignore_hazard), .forward_en(forward_en),
    .stall(stall), .busy_vector(busy_vector), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_hit(input int s);
    return forward_en ? (m_ldp[s] > 0) : (m_pend[s] > 0);
  endfunction

  function automatic bit model_stall();
    if (ignore_hazard) return 1'b0;
    return model_hit(int'(src1_address)) || (have_two_src && model_hit(int'(src2_address)));
  endfunction

  function automatic logic [15:0] model_busy();
    logic [15:0] b;
    for (int r = 0; r < 16; r++) b[r] = (m_pend[r] > 0);
    return b;
  endfunction

  // Applies the current inputs to the model, then advances one clock.
  task automatic clk_step();
    bit acc;
    int np [16];
    int nl [16];
    acc = issue_valid && issue_wb_en && !flush && !model_stall();
    if (!rst) begin
      for (int r = 0; r < 16; r++) begin m_pend[r] = 0; m_ldp[r] = 0; end
      m_err = 1'b0;
    end else begin
      np = m_pend;
      nl = m_ldp;
      if (acc) begin
        np[issue_dest] += 1;
        if (issue_is_load) nl[issue_dest] += 1;
      end
      if (wb_valid) begin
        np[wb_dest] -= 1;
        if (wb_was_load) nl[wb_dest] -= 1;
      end
      for (int r = 0; r < 16; r++) begin
        if (np[r] > 3) begin np[r] = 3; m_err = 1'b1; end
        if (np[r] < 0) begin np[r] = 0; m_err = 1'b1; end
        if (nl[r] > 3) begin nl[r] = 3; m_err = 1'b1; end
        if (nl[r] < 0) begin nl[r] = 0; m_err = 1'b1; end
        if (nl[r] > np[r]) nl[r] = np[r];
      end
      m_pend = np;
      m_ldp  = nl;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b1; issue_valid = 1'b0; issue_wb_en = 1'b0; issue_is_load = 1'b0;
    issue_dest = 4'd0; flush = 1'b0; wb_valid = 1'b0; wb_dest = 4'd0;
    wb_was_load = 1'b0; src1_address = 4'd0; src2_address = 4'd0;
    have_two_src = 1'b0; ignore_hazard = 1'b1; forward_en = 1'b0;
  endtask

  task automatic do_issue(input logic [3:0] d, input logic ld);
    idle();
    issue_valid = 1'b1; issue_wb_en = 1'b1; issue_is_load = ld; issue_dest = d;
    clk_step();
  endtask

  task automatic do_wb(input logic [3:0] d, input logic ld);
    idle();
    wb_valid = 1'b1; wb_dest = d; wb_was_load = ld;
    clk_step();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    clk_step();
    idle();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", stall); end
    checks++; if (busy_vector !== 16'h0000) begin errors++; $display("FAIL reset_busy got %h exp 0000", busy_vector); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", err); end
  endtask

  task automatic test_basic();
    do_issue(4'd3, 1'b0);
    idle(); ignore_hazard = 1'b0; src1_address = 4'd3; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL basic_stall got %0b exp 1", stall); end
    checks++; if (busy_vector !== 16'h0008) begin errors++; $display("FAIL basic_busy got %h exp 0008", busy_vector); end
    wb_valid = 1'b1; wb_dest = 4'd3; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL basic_no_bypass got %0b exp 1", stall); end
    clk_step();
    idle(); ignore_hazard = 1'b0; src1_address = 4'd3; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL basic_release got %0b exp 0", stall); end
    checks++; if (busy_vector !== 16'h0000) begin errors++; $display("FAIL basic_busy_clr got %h exp 0000", busy_vector); end
  endtask

  task automatic test_forward();
    do_issue(4'd5, 1'b1);
    idle(); ignore_hazard = 1'b0; forward_en = 1'b1; src2_address = 4'd5; have_two_src = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fwd_load_src2 got %0b exp 1", stall); end
    have_two_src = 1'b0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_one_src got %0b exp 0", stall); end
    do_wb(4'd5, 1'b1);
    do_issue(4'd5, 1'b0);
    idle(); ignore_hazard = 1'b0; forward_en = 1'b1; src1_address = 4'd5; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_nonload got %0b exp 0", stall); end
    forward_en = 1'b0; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL nofwd_nonload got %0b exp 1", stall); end
    do_wb(4'd5, 1'b0);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 3; i++) do_issue(4'd2, 1'b0);
    idle(); #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sat_three_err got %0b exp 0", err); end
    do_issue(4'd2, 1'b0);
    idle(); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL sat_four_err got %0b exp 1", err); end
    do_wb(4'd2, 1'b0);
    do_wb(4'd2, 1'b0);
    idle(); #1;
    checks++; if (busy_vector[2] !== 1'b1) begin errors++; $display("FAIL sat_held got %0b exp 1", busy_vector[2]); end
    do_wb(4'd2, 1'b0);
    idle(); #1;
    checks++; if (busy_vector[2] !== 1'b0) begin errors++; $display("FAIL sat_drain got %0b exp 0", busy_vector[2]); end
    idle(); rst = 1'b0; clk_step(); idle();
  endtask

  task automatic test_same_cycle();
    do_issue(4'd7, 1'b0);
    idle();
    issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 4'd7;
    wb_valid = 1'b1; wb_dest = 4'd7;
    clk_step();
    idle(); #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL same_err got %0b exp 0", err); end
    checks++; if (busy_vector !== 16'h0080) begin errors++; $display("FAIL same_busy got %h exp 0080", busy_vector); end
    do_wb(4'd7, 1'b0);
    idle(); #1;
    checks++; if (busy_vector !== 16'h0000 || err !== 1'b0) begin
      errors++; $display("FAIL same_drain got busy %h err %0b exp 0000 0", busy_vector, err);
    end
  endtask

  task automatic test_blocked();
    idle();
    issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 4'd4; flush = 1'b1;
    clk_step();
    idle(); #1;
    checks++; if (busy_vector !== 16'h0000) begin errors++; $display("FAIL flush_drop got %h exp 0000", busy_vector); end
    do_issue(4'd6, 1'b0);
    idle();
    ignore_hazard = 1'b0; src1_address = 4'd6;
    issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 4'd8;
    clk_step();
    idle(); #1;
    checks++; if (busy_vector !== 16'h0040) begin errors++; $display("FAIL stall_drop got %h exp 0040", busy_vector); end
    do_wb(4'd6, 1'b0);
  endtask

  task automatic test_err_reset();
    do_wb(4'd9, 1'b0);
    idle(); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL underflow_err got %0b exp 1", err); end
    clk_step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b exp 1", err); end
    do_issue(4'd1, 1'b1);
    idle(); rst = 1'b0; clk_step();
    idle(); ignore_hazard = 1'b0; src1_address = 4'd1; #1;
    checks++; if (err !== 1'b0 || busy_vector !== 16'h0000 || stall !== 1'b0) begin
      errors++; $display("FAIL rst_clear got err %0b busy %h stall %0b exp 0 0000 0", err, busy_vector, stall);
    end
    do_wb(4'd1, 1'b1);
    idle(); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL post_rst_wb got %0b exp 1", err); end
    idle(); rst = 1'b0; clk_step(); idle();
  endtask

  task automatic test_random();
    bit exp_st;
    int busy_list [$];
    for (int n = 0; n < 600; n++) begin
      idle();
      rst           = ($urandom_range(0, 99) != 0);
      issue_valid   = ($urandom_range(0, 1) == 1);
      issue_wb_en   = ($urandom_range(0, 3) != 0);
      issue_is_load = ($urandom_range(0, 2) == 0);
      issue_dest    = 4'($urandom_range(0, 15));
      flush         = ($urandom_range(0, 7) == 0);
      src1_address  = 4'($urandom_range(0, 15));
      src2_address  = 4'($urandom_range(0, 15));
      have_two_src  = ($urandom_range(0, 1) == 1);
      ignore_hazard = ($urandom_range(0, 7) == 0);
      forward_en    = ($urandom_range(0, 1) == 1);
      wb_valid      = ($urandom_range(0, 9) < 4);
      busy_list.delete();
      for (int r = 0; r < 16; r++) if (m_pend[r] > 0) busy_list.push_back(r);
      if (busy_list.size() > 0 && $urandom_range(0, 7) != 0)
        wb_dest = 4'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
      else
        wb_dest = 4'($urandom_range(0, 15));
      wb_was_load = (m_ldp[wb_dest] > 0) ^ ($urandom_range(0, 7) == 0);
      #1;
      exp_st = model_stall();
      checks++; if (stall !== exp_st) begin errors++; $display("FAIL rand_stall cyc %0d got %0b exp %0b", n, stall, exp_st); end
      checks++; if (busy_vector !== model_busy()) begin errors++; $display("FAIL rand_busy cyc %0d got %h exp %h", n, busy_vector, model_busy()); end
      checks++; if (err !== m_err) begin errors++; $display("FAIL rand_err cyc %0d got %0b exp %0b", n, err, m_err); end
      clk_step();
    end
  endtask

  initial begin
    for (int r = 0; r < 16; r++) begin m_pend[r] = 0; m_ldp[r] = 0; end
    m_err = 1'b0;
    idle();
    rst = 1'b0;
    test_reset();
    test_basic();
    test_forward();
    test_saturate();
    test_same_cycle();
    test_blocked();
    test_err_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
